flit_tx_channel: RTL and testbench

- Output side of a router port: drains flits from the input-channel FIFO and transmits them on the inter-router link.
- Requests the output port from the switch arbiter on a head flit and holds it until the tail flit is sent.
- Credit-based flow control against the downstream router's FIFO depth.
- Sits between the FIFO read side (empty/read/data) and the link wires.

---
 rtl/flit_tx_channel.sv | 185 ++++++++++++++++++
 tb/tb_flit_tx_channel.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_tx_channel.sv
// flit_tx_channel
//   Output side of a router port. Pops flits from the input-channel FIFO,
//   arbitrates for the output port on a head flit, holds the port until the
//   tail flit leaves, and throttles the link with credit-based flow control
//   against the downstream FIFO.
//
// Optional build macro: FLIT_TX_PKT_CNT_EN
//   When defined, adds output pkt_cnt, a wrapping 16-bit count of
//   completed packets (tail or single flit sent).
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous reset, active low
//   fifo_data  in   flit at the FIFO read pointer (combinational)
//   fifo_empty in   FIFO empty flag
//   fifo_read  out  pop strobe, one flit per asserted cycle
//   req        out  output-port request to the switch arbiter
//   grant      in   arbiter grant (level)
//   credit_in  in   one-cycle pulse, downstream freed one slot
//   tx_data    out  registered link data
//   tx_valid   out  registered link valid
//   err        out  registered one-cycle protocol-error pulse
//   pkt_cnt    out  completed packet count (FLIT_TX_PKT_CNT_EN only)
//
// Flit type in the top two bits: 01 head, 00 body, 10 tail, 11 single.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no packet owned; waiting for a head/single at the FIFO
// REQ     | head waiting at the FIFO; requesting the output port
// SEND    | port owned; sending flits while credit allows until tail

module flit_tx_channel #(
  parameter int DATA_WIDTH  = 8,
  parameter int CREDIT_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic                  req,
  input  logic                  grant,
  input  logic                  credit_in,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  err
`ifdef FLIT_TX_PKT_CNT_EN
  ,
  output logic [15:0]           pkt_cnt
`endif
);

  localparam logic [CREDIT_BITS:0] CREDIT_MAX = {1'b1, {CREDIT_BITS{1'b0}}};
  localparam logic [CREDIT_BITS:0] CREDIT_ONE = {{CREDIT_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CREDIT_BITS:0]    credit_q, credit_d;
  logic                    first_q, first_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic                    err_q, err_d;

  logic                    pop;
  logic                    send;
  logic                    pkt_end;
  logic                    is_head;
  logic                    is_tail;

  // Top bit set = tail/single, next bit set = head/single.
  assign is_tail = fifo_data[DATA_WIDTH-1];
  assign is_head = fifo_data[DATA_WIDTH-2];

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    first_d    = first_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    pop        = 1'b0;
    send       = 1'b0;
    pkt_end    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_head) begin
            state_d = ST_REQ;
          end else begin
            // Stray body/tail with no owning packet: drop it.
            pop   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (grant) begin
          state_d = ST_SEND;
          first_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (!fifo_empty && (credit_q != '0)) begin
          send       = 1'b1;
          pop        = 1'b1;
          tx_data_d  = fifo_data;
          tx_valid_d = 1'b1;
          first_d    = 1'b0;
          // first_q marks the packet's own head; any later head/single is
          // a protocol error and is forwarded without ending the packet.
          if (is_head && !first_q) begin
            err_d = 1'b1;
          end else if (is_tail) begin
            state_d = ST_IDLE;
            pkt_end = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case ({send, credit_in})
      2'b10: credit_d = credit_q - CREDIT_ONE;
      2'b01: begin
        if (credit_q == CREDIT_MAX) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + CREDIT_ONE;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      credit_q   <= CREDIT_MAX;
      first_q    <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      first_q    <= first_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Gate the pop with reset so the FIFO is never drained while held in reset.
  assign fifo_read = pop & rst;
  assign req       = (state_q != ST_IDLE);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign err       = err_q;

`ifdef FLIT_TX_PKT_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_cnt_d = pkt_end ? (pkt_cnt_q + 16'd1) : pkt_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_flit_tx_channel.sv
// Testbench for flit_tx_channel: directed scenarios plus a randomized packet
// stream checked against a flit-order scoreboard and a credit ledger.
module tb_flit_tx_channel;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_read;
  logic       req;
  logic       grant;
  logic       credit_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       err;
`ifdef FLIT_TX_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  int total = 0;
  int bad   = 0;

  flit_tx_channel #(.DATA_WIDTH(8), .CREDIT_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .req       (req),
    .grant     (grant),
    .credit_in (credit_in),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .err       (err)
`ifdef FLIT_TX_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: pushes staged at negedge land at the next posedge.
  logic [7:0] fq[$];
  logic [7:0] pq[$];
  logic [7:0] popped;
  logic       flush_req = 1'b0;
  int         empty_pop = 0;

  initial begin
    fifo_data  = 8'h00;
    fifo_empty = 1'b1;
  end

  always @(posedge clk) begin
    if (flush_req) begin
      fq.delete();
      pq.delete();
    end else begin
      if (fifo_read && fq.size() > 0) popped = fq.pop_front();
      while (pq.size() > 0) fq.push_back(pq.pop_front());
    end
    fifo_empty <= (fq.size() == 0);
    fifo_data  <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (fifo_read && fifo_empty) empty_pop++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] f);
    pq.push_back(f);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    credit_in = 1'b0;
    grant     = 1'b1;
    flush_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush_req = 1'b0;
    rst       = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(tx_valid), 32'd1);
  endtask

  logic [7:0] pkt2[4] = '{8'h41, 8'h02, 8'h03, 8'h84};
  logic [7:0] pkt3[6] = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h85};

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] f;
    logic [1:0] ty;
    int strays, npkt, len, outstanding, ovf, err_seen, cyc, ncmp;

    // T1: single flit, minimum latency with grant tied high
    rst = 1'b0; grant = 1'b1; credit_in = 1'b0;
    push(8'hC5);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_fifo_read", 32'(fifo_read), 32'd0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_credit", 32'(dut.credit_q), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t1_req_c1", 32'(req), 32'd1);
    check_eq("t1_noread_c1", 32'(fifo_read), 32'd0);
    @(negedge clk);
    check_eq("t1_read_c2", 32'(fifo_read), 32'd1);
    @(negedge clk);
    check_eq("t1_valid_c3", 32'(tx_valid), 32'd1);
    check_eq("t1_data_c3", 32'(tx_data), 32'hC5);
    check_eq("t1_req_low", 32'(req), 32'd0);
    check_eq("t1_credit", 32'(dut.credit_q), 32'd3);

    // T2: 4-flit packet uses all credit, back to back
    do_reset();
    for (int i = 0; i < 4; i++) push(pkt2[i]);
    wait_valid("t2_start", 20);
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_valid", 32'(tx_valid), 32'd1);
      check_eq("t2_data", 32'(tx_data), 32'(pkt2[i]));
      if (i < 3) @(negedge clk);
    end
    check_eq("t2_req_low", 32'(req), 32'd0);
    check_eq("t2_credit", 32'(dut.credit_q), 32'd0);

    // T3: 6-flit packet stalls on credit, resumes after a pulse
    do_reset();
    for (int i = 0; i < 6; i++) push(pkt3[i]);
    wait_valid("t3_start", 20);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_data", 32'(tx_data), 32'(pkt3[i]));
      check_eq("t3_valid", 32'(tx_valid), 32'd1);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_bubble", 32'(tx_valid), 32'd0);
      check_eq("t3_stall_read", 32'(fifo_read), 32'd0);
      @(negedge clk);
    end
    check_eq("t3_credit0", 32'(dut.credit_q), 32'd0);
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    check_eq("t3_pop5", 32'(fifo_read), 32'd1);
    @(negedge clk);
    check_eq("t3_valid5", 32'(tx_valid), 32'd1);
    check_eq("t3_data5", 32'(tx_data), 32'(pkt3[4]));
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    @(negedge clk);
    check_eq("t3_data6", 32'(tx_data), 32'(pkt3[5]));
    check_eq("t3_req_low", 32'(req), 32'd0);

    // T4: credit_in together with a send; credit_in at maximum
    do_reset();
    push(8'h41);
    push(8'h02);
    wait_valid("t4_start", 20);
    @(negedge clk);
    check_eq("t4_credit2", 32'(dut.credit_q), 32'd2);
    push(8'h86);
    @(negedge clk);
    check_eq("t4_read", 32'(fifo_read), 32'd1);
    credit_in = 1'b1;
    @(negedge clk);
    credit_in = 1'b0;
    check_eq("t4_tail", 32'(tx_data), 32'h86);
    check_eq("t4_credit_same", 32'(dut.credit_q), 32'd2);
    credit_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_err_below_max", 32'(err), 32'd0);
    @(negedge clk);
    credit_in = 1'b0;
    check_eq("t4_err_at_max", 32'(err), 32'd1);
    check_eq("t4_credit4", 32'(dut.credit_q), 32'd4);
    @(negedge clk);
    check_eq("t4_err_pulse", 32'(err), 32'd0);

    // T5: stray body flit in IDLE
    do_reset();
    push(8'h07);
    @(negedge clk);
    check_eq("t5_pop", 32'(fifo_read), 32'd1);
    check_eq("t5_req0", 32'(req), 32'd0);
    @(negedge clk);
    check_eq("t5_err", 32'(err), 32'd1);
    check_eq("t5_novalid", 32'(tx_valid), 32'd0);
    check_eq("t5_req1", 32'(req), 32'd0);
    @(negedge clk);
    check_eq("t5_err_clr", 32'(err), 32'd0);
    check_eq("t5_req2", 32'(req), 32'd0);

    // T6: reset while flit 3 of 4 is being popped
    do_reset();
    for (int i = 0; i < 4; i++) push(pkt2[i]);
    wait_valid("t6_start", 20);
    @(negedge clk);
    check_eq("t6_pre_read", 32'(fifo_read), 32'd1);
    rst = 1'b0;
    flush_req = 1'b1;
    #1;
    check_eq("t6_valid0", 32'(tx_valid), 32'd0);
    check_eq("t6_req0", 32'(req), 32'd0);
    check_eq("t6_read0", 32'(fifo_read), 32'd0);
    check_eq("t6_credit4", 32'(dut.credit_q), 32'd4);
    @(negedge clk);
    flush_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push(8'hC9);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_new_req", 32'(req), 32'd1);
    wait_valid("t6_new_pkt", 20);
    check_eq("t6_new_data", 32'(tx_data), 32'hC9);

    // Random packet stream against scoreboard and credit ledger
    do_reset();
`ifdef FLIT_TX_PKT_CNT_EN
    check_eq("pkt_cnt_rst", 32'(pkt_cnt), 32'd0);
`endif
    strays = 0;
    npkt = 30;
    for (int p = 0; p < npkt; p++) begin
      if ($urandom_range(0, 4) == 0) begin
        ty = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
        f = {ty, 6'($urandom)};
        push(f);
        strays++;
      end
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        if (len == 1)          ty = 2'b11;
        else if (k == 0)       ty = 2'b01;
        else if (k == len - 1) ty = 2'b10;
        else                   ty = 2'b00;
        f = {ty, 6'($urandom)};
        push(f);
        exp_q.push_back(f);
      end
    end
    outstanding = 0;
    ovf = 0;
    err_seen = 0;
    cyc = 0;
    while (cyc < 5000 && !(got_q.size() == exp_q.size() && outstanding == 0)) begin
      @(negedge clk);
      cyc++;
      grant = 1'($urandom_range(0, 1));
      credit_in = 1'b0;
      if (err) err_seen++;
      if (tx_valid) begin
        got_q.push_back(tx_data);
        outstanding++;
        if (outstanding > 4) ovf++;
      end
      if (outstanding > 0 && $urandom_range(0, 2) == 0) begin
        credit_in = 1'b1;
        outstanding--;
      end
    end
    @(negedge clk);
    credit_in = 1'b0;
    if (err) err_seen++;
    @(negedge clk);
    if (err) err_seen++;
    check_eq("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
    ncmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < ncmp; i++) check_eq("rnd_flit", 32'(got_q[i]), 32'(exp_q[i]));
    check_eq("rnd_err", 32'(err_seen), 32'(strays));
    check_eq("rnd_credit_ovf", 32'(ovf), 32'd0);
    check_eq("rnd_credit_end", 32'(dut.credit_q), 32'd4);
    check_eq("rnd_req_end", 32'(req), 32'd0);
`ifdef FLIT_TX_PKT_CNT_EN
    check_eq("pkt_cnt", 32'(pkt_cnt), 32'(npkt));
`endif
    check_eq("empty_pop", 32'(empty_pop), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
